// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer
// Packs DATA_BYTES consecutive 8-bit filtered pixels into one wide AXI-Stream
// word for the S2MM DMA. A frame-terminating last may arrive mid-word, in which
// case a partial word is emitted with a matching keep mask. Also reports the
// pixel count of each completed frame and a one-cycle frame-done pulse.
//
// Ports:
//   axi_clk, axi_reset_n             clock, synchronous active-low reset
//   s_data_valid/s_data/s_data_last  pixel stream in (from imageProcessTop)
//   s_data_ready                     pixel accept (combinational from m_data_ready)
//   m_data_valid/m_data/m_data_keep/m_data_last/m_data_ready  packed word out
//   o_pixel_count                    pixel count of the most recent completed frame
//   o_frame_done                     pulse the cycle after the last word's handshake
module pixel_stream_packer #(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned CNT_W      = 20
) (
  input  logic                    axi_clk,
  input  logic                    axi_reset_n,
  input  logic                    s_data_valid,
  input  logic [7:0]              s_data,
  input  logic                    s_data_last,
  output logic                    s_data_ready,
  output logic                    m_data_valid,
  output logic [8*DATA_BYTES-1:0] m_data,
  output logic [DATA_BYTES-1:0]   m_data_keep,
  output logic                    m_data_last,
  input  logic                    m_data_ready,
  output logic [CNT_W-1:0]        o_pixel_count,
  output logic                    o_frame_done
);

  localparam int unsigned         IDX_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DATA_BYTES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

  // Assembly register
  logic [DATA_BYTES-1:0][7:0] r_lanes;
  logic [DATA_BYTES-1:0]      r_keep;
  logic [IDX_W-1:0]           r_idx;

  // Output register
  logic                       r_m_valid;
  logic [DATA_BYTES-1:0][7:0] r_m_data;
  logic [DATA_BYTES-1:0]      r_m_keep;
  logic                       r_m_last;

  // Frame counter and status
  logic [CNT_W-1:0]           r_cnt;
  logic [CNT_W-1:0]           r_pixel_count;
  logic                       r_frame_done;

  logic                       w_ready;
  logic                       w_accept;
  logic                       w_complete;
  logic                       w_out_hs;
  logic [DATA_BYTES-1:0][7:0] w_lanes_next;
  logic [DATA_BYTES-1:0]      w_keep_next;
  logic [CNT_W-1:0]           w_cnt_inc;

  // Input may proceed whenever the output slot is empty or draining this cycle.
  assign w_ready    = !r_m_valid || m_data_ready;
  assign w_accept   = s_data_valid && w_ready;
  assign w_complete = w_accept && ((r_idx == LAST_IDX) || s_data_last);
  assign w_out_hs   = r_m_valid && m_data_ready;
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  // Lanes/keep with the current pixel merged in; unfilled lanes stay zero
  // because the assembly register is cleared after every completed word.
  always_comb begin
    w_lanes_next        = r_lanes;
    w_keep_next         = r_keep | (DATA_BYTES'(1) << r_idx);
    w_lanes_next[r_idx] = s_data;
  end

  // Assembly register
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_lanes <= '0;
      r_keep  <= '0;
      r_idx   <= '0;
    end else if (w_complete) begin
      r_lanes <= '0;
      r_keep  <= '0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_lanes <= w_lanes_next;
      r_keep  <= w_keep_next;
      r_idx   <= r_idx + IDX_W'(1);
    end
  end

  // Output register: a completing word overrides the drain, so no bubble.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_complete) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_lanes_next;
      r_m_keep  <= w_keep_next;
      r_m_last  <= s_data_last;
    end else if (w_out_hs) begin
      r_m_valid <= 1'b0;
    end
  end

  // Saturating frame pixel counter; count published on the last pixel.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_cnt         <= '0;
      r_pixel_count <= '0;
    end else if (w_accept) begin
      if (s_data_last) begin
        r_cnt         <= '0;
        r_pixel_count <= w_cnt_inc;
      end else begin
        r_cnt         <= w_cnt_inc;
      end
    end
  end

  // Frame-done pulse follows the handshake of a last word.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_out_hs && r_m_last;
    end
  end

  assign s_data_ready  = w_ready;
  assign m_data_valid  = r_m_valid;
  assign m_data        = r_m_data;
  assign m_data_keep   = r_m_keep;
  assign m_data_last   = r_m_last;
  assign o_pixel_count = r_pixel_count;
  assign o_frame_done  = r_frame_done;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Scoreboard bench for pixel_stream_packer (DATA_BYTES=4, CNT_W=20).
// Stimulus pushes expected words {data, keep, last}; a negedge monitor pops and
// compares on every output handshake and tracks the frame-done pulse.
module tb_pixel_stream_packer;

  logic        axi_clk;
  logic        axi_reset_n;
  logic        s_data_valid;
  logic [7:0]  s_data;
  logic        s_data_last;
  logic        s_data_ready;
  logic        m_data_valid;
  logic [31:0] m_data;
  logic [3:0]  m_data_keep;
  logic        m_data_last;
  logic        m_data_ready;
  logic [19:0] o_pixel_count;
  logic        o_frame_done;

  pixel_stream_packer #(.DATA_BYTES(4), .CNT_W(20)) dut (
    .axi_clk      (axi_clk),
    .axi_reset_n  (axi_reset_n),
    .s_data_valid (s_data_valid),
    .s_data       (s_data),
    .s_data_last  (s_data_last),
    .s_data_ready (s_data_ready),
    .m_data_valid (m_data_valid),
    .m_data       (m_data),
    .m_data_keep  (m_data_keep),
    .m_data_last  (m_data_last),
    .m_data_ready (m_data_ready),
    .o_pixel_count(o_pixel_count),
    .o_frame_done (o_frame_done)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  int n_vec;
  int n_err;
  int n_stall;
  int fd_cnt;
  logic exp_fd;
  logic [36:0] q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
    q.push_back({d, k, l});
  endtask

  // Monitor: handshake seen at negedge completes at the following posedge.
  always @(negedge axi_clk) begin
    if (exp_fd || o_frame_done) begin
      n_vec++;
      if (o_frame_done !== exp_fd) begin
        n_err++;
        $display("FAIL frame_done_pulse: got %b, expected %b", o_frame_done, exp_fd);
      end
    end
    if (o_frame_done === 1'b1) fd_cnt++;
    exp_fd = axi_reset_n && m_data_valid && m_data_ready && m_data_last;
    if (axi_reset_n && m_data_valid && m_data_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got data 0x%08h keep 0x%0h last %b, expected none",
                 m_data, m_data_keep, m_data_last);
      end else begin
        logic [36:0] e;
        e = q.pop_front();
        n_vec++;
        if ({m_data, m_data_keep, m_data_last} !== e) begin
          n_err++;
          $display("FAIL word: got data 0x%08h keep 0x%0h last %b, expected data 0x%08h keep 0x%0h last %b",
                   m_data, m_data_keep, m_data_last, e[36:5], e[4:1], e[0]);
        end
      end
    end
  end

  // Present one pixel and return #1 after the edge that accepts it; valid stays high.
  task automatic send(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    s_data_valid = 1'b1;
    s_data       = d;
    s_data_last  = l;
    @(negedge axi_clk);
    while (!s_data_ready && t < 200) begin
      t++;
      @(negedge axi_clk);
    end
    if (!s_data_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got ready 0 after %0d cycles, expected 1", t);
    end
    n_stall += t;
    @(posedge axi_clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_data_valid = 1'b0;
    s_data_last  = 1'b0;
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  task automatic do_reset();
    s_data_valid = 1'b0;
    s_data_last  = 1'b0;
    axi_reset_n  = 1'b0;
    @(posedge axi_clk);
    #1;
    axi_reset_n  = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 1000) begin
      @(posedge axi_clk);
      t++;
    end
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
    idle(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int fd0;
    int st0;
    n_vec = 0; n_err = 0; n_stall = 0; fd_cnt = 0; exp_fd = 1'b0;
    axi_reset_n  = 1'b0;
    s_data_valid = 1'b0;
    s_data       = 8'h00;
    s_data_last  = 1'b0;
    m_data_ready = 1'b1;
    repeat (2) @(posedge axi_clk);
    #1;
    axi_reset_n = 1'b1;

    // Reset state
    chk("rst_m_valid", 64'(m_data_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_keep", 64'(m_data_keep), 64'd0);
    chk("rst_m_last", 64'(m_data_last), 64'd0);
    chk("rst_pixel_count", 64'(o_pixel_count), 64'd0);
    chk("rst_frame_done", 64'(o_frame_done), 64'd0);
    chk("rst_s_ready", 64'(s_data_ready), 64'd1);

    // Full word, presented the cycle after the completing accept
    push(32'h44332211, 4'hF, 1'b0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    chk("latency_valid", 64'(m_data_valid), 64'd1);
    chk("latency_data", 64'(m_data), 64'h44332211);
    idle(1);
    drain();
    do_reset();

    // Partial last word
    fd0 = fd_cnt;
    push(32'h44332211, 4'hF, 1'b0);
    push(32'h00006655, 4'h3, 1'b1);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    send(8'h44, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b1);
    idle(1);
    drain();
    chk("partial_pixel_count", 64'(o_pixel_count), 64'd6);
    chk("partial_frame_done_cnt", 64'(fd_cnt - fd0), 64'd1);
    do_reset();

    // Backpressure: ready low for 10 cycles while streaming 12 pixels
    push(32'h44332211, 4'hF, 1'b0);
    push(32'h88776655, 4'hF, 1'b0);
    push(32'hCCBBAA99, 4'hF, 1'b0);
    m_data_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 12; i++) send(8'(i * 17), 1'b0);
        s_data_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge axi_clk);
        repeat (5) begin
          @(negedge axi_clk);
          chk("bp_s_ready_low", 64'(s_data_ready), 64'd0);
          chk("bp_m_data_hold", 64'(m_data), 64'h44332211);
        end
        repeat (2) @(posedge axi_clk);
        #1;
        m_data_ready = 1'b1;
      end
    join
    idle(1);
    drain();
    do_reset();

    // Single-pixel frame
    fd0 = fd_cnt;
    push(32'h000000AB, 4'h1, 1'b1);
    send(8'hAB, 1'b1);
    idle(1);
    drain();
    chk("single_pixel_count", 64'(o_pixel_count), 64'd1);
    chk("single_frame_done_cnt", 64'(fd_cnt - fd0), 64'd1);

    // Reset mid-frame discards the partial word
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    do_reset();
    chk("midrst_m_valid", 64'(m_data_valid), 64'd0);
    chk("midrst_pixel_count", 64'(o_pixel_count), 64'd0);
    push(32'hA4A3A2A1, 4'hF, 1'b0);
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0); send(8'hA4, 1'b0);
    idle(1);
    drain();
    do_reset();

    // Throughput: two back-to-back 2048-pixel frames
    fd0 = fd_cnt;
    st0 = n_stall;
    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < 512; w++) begin
        for (int b = 0; b < 4; b++) send(8'(4 * w + b), (w == 511) && (b == 3));
        push({8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)}, 4'hF, w == 511);
      end
      chk("tput_pixel_count", 64'(o_pixel_count), 64'd2048);
    end
    idle(1);
    drain();
    chk("tput_stalls", 64'(n_stall - st0), 64'd0);
    chk("tput_frame_done_cnt", 64'(fd_cnt - fd0), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
